// File: rtl/boundary_link_rx_pkg.sv
// ---------------------------------------------------------------------------
// boundary_link_rx_pkg
// Shared definitions for the partition-boundary link blocks: decoder stage
// codes, the RX state encoding (also meant for the future tx block) and a
// small sizing helper.
// ---------------------------------------------------------------------------
package boundary_link_rx_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_DECODING            = 3'd2;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_ASSEMBLE = 2'd1,
        RX_DELIVER  = 2'd2
    } rx_state_t;

    // Number of whole flits needed to carry a message of the given width.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/boundary_link_rx_if.sv
// ---------------------------------------------------------------------------
// boundary_link_rx_if
// Bundles the incoming flit channel and the per-link FIFO delivery bus.
//   rx_flit_data/sof/valid  : flit stream from the boundary channel
//   rx_flit_ready           : receiver can take a flit this cycle
//   fifo_input_data/valid   : per-link one-beat delivery, link i at slice i
//   fifo_input_ready        : per-link accept
// Modport slave is the receiver's view, master is the channel/FIFO side.
// ---------------------------------------------------------------------------
interface boundary_link_rx_if #(
    parameter int NUM_LINKS      = 8,
    parameter int FLIT_WIDTH     = 8,
    parameter int FIFO_DATA_SIZE = 10
);
    logic [FLIT_WIDTH-1:0]                rx_flit_data;
    logic                                 rx_flit_sof;
    logic                                 rx_flit_valid;
    logic                                 rx_flit_ready;
    logic [NUM_LINKS*FIFO_DATA_SIZE-1:0]  fifo_input_data;
    logic [NUM_LINKS-1:0]                 fifo_input_valid;
    logic [NUM_LINKS-1:0]                 fifo_input_ready;

    modport slave (
        input  rx_flit_data, rx_flit_sof, rx_flit_valid,
        output rx_flit_ready,
        output fifo_input_data, fifo_input_valid,
        input  fifo_input_ready
    );

    modport master (
        output rx_flit_data, rx_flit_sof, rx_flit_valid,
        input  rx_flit_ready,
        input  fifo_input_data, fifo_input_valid,
        output fifo_input_ready
    );
endinterface

// File: rtl/boundary_link_rx_flit_deserializer.sv
// ---------------------------------------------------------------------------
// flit_deserializer
// Slot register that rebuilds a message from flits (flit 0 = LSBs) plus the
// count of flits stored so far.
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : drop the flit count (stage flush)
//   load_first   : store flit_in as flit 0, count becomes 1
//   load_next    : store flit_in at slot count, count increments
//   flit_in      : flit payload
//   msg_out      : message image including any flit loaded this cycle, so
//                  the caller can decode the complete message on the edge
//                  that accepts the last flit
//   count        : flits currently stored
// ---------------------------------------------------------------------------
module flit_deserializer #(
    parameter int FLIT_WIDTH  = 8,
    parameter int MSG_WIDTH   = 13,
    parameter int NUM_FLITS   = 2,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load_first,
    input  logic                   load_next,
    input  logic [FLIT_WIDTH-1:0]  flit_in,
    output logic [MSG_WIDTH-1:0]   msg_out,
    output logic [COUNT_WIDTH-1:0] count
);
    logic [MSG_WIDTH-1:0]   msg_q;
    logic [MSG_WIDTH-1:0]   msg_next;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_next;

    // Build the next slot image bit by bit; bits of the last flit beyond
    // MSG_WIDTH simply have no destination and are dropped.
    always_comb begin
        msg_next   = msg_q;
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (load_first) begin
            msg_next = '0;
            for (int b = 0; b < FLIT_WIDTH && b < MSG_WIDTH; b++) begin
                msg_next[b] = flit_in[b];
            end
            count_next = COUNT_WIDTH'(1);
        end else if (load_next) begin
            for (int b = 0; b < MSG_WIDTH; b++) begin
                if (COUNT_WIDTH'(b / FLIT_WIDTH) == count_q) begin
                    msg_next[b] = flit_in[b % FLIT_WIDTH];
                end
            end
            count_next = count_q + 1'b1;
        end
    end

    // Slot register and flit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_q   <= '0;
            count_q <= '0;
        end else begin
            msg_q   <= msg_next;
            count_q <= count_next;
        end
    end

    assign msg_out = msg_next;
    assign count   = count_q;

endmodule

// File: rtl/boundary_link_rx.sv
// ---------------------------------------------------------------------------
// boundary_link_rx
// Receive end of the inter-partition link. Reassembles flits into
// {link_id, growth, exposed_data} and hands {growth, exposed_data} to the
// addressed neighbour link as a held one-hot valid/data beat.
//   clk, reset      : clock, asynchronous active-low reset
//   global_stage    : decoder stage; measurement loading flushes the block
//   bus (slave)     : flit channel in, per-link FIFO delivery out
//   framing_error   : sticky, sof/non-sof protocol violation seen
//   bad_link_error  : sticky, decoded link_id >= NUM_LINKS
//   msg_count       : delivered messages, saturating
// ---------------------------------------------------------------------------
module boundary_link_rx
    import boundary_link_rx_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int NUM_LINKS     = 8,
    parameter int FLIT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] global_stage,
    boundary_link_rx_if.slave      bus,
    output logic                   framing_error,
    output logic                   bad_link_error,
    output logic [15:0]            msg_count
);
    localparam int FIFO_DATA_SIZE = ADDRESS_WIDTH + 4;
    localparam int LINK_ID_WIDTH  = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
    localparam int MSG_WIDTH      = LINK_ID_WIDTH + FIFO_DATA_SIZE;
    localparam int NUM_FLITS      = ceil_div(MSG_WIDTH, FLIT_WIDTH);
    localparam int COUNT_WIDTH    = $clog2(NUM_FLITS + 1);
    localparam int DATA_WIDTH     = NUM_LINKS * FIFO_DATA_SIZE;

    rx_state_t                state;
    rx_state_t                next_state;
    logic                     flush;
    logic                     accept;
    logic                     load_first;
    logic                     load_next;
    logic                     complete;
    logic                     start_delivery;
    logic                     delivered;
    logic                     set_framing;
    logic                     set_bad;
    logic [COUNT_WIDTH-1:0]   count;
    logic [MSG_WIDTH-1:0]     msg;
    logic [LINK_ID_WIDTH-1:0] link_id;
    logic [LINK_ID_WIDTH-1:0] link_q;
    logic [NUM_LINKS-1:0]     valid_q;
    logic [DATA_WIDTH-1:0]    data_q;

    // During measurement loading the channel is drained, so ready stays high.
    assign flush             = (global_stage == STAGE_MEASUREMENT_LOADING);
    assign bus.rx_flit_ready = flush || (state != RX_DELIVER);
    assign accept            = bus.rx_flit_valid && bus.rx_flit_ready;
    assign link_id           = msg[MSG_WIDTH-1 -: LINK_ID_WIDTH];

    flit_deserializer #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .MSG_WIDTH  (MSG_WIDTH),
        .NUM_FLITS  (NUM_FLITS),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_deser (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load_first(load_first),
        .load_next (load_next),
        .flit_in   (bus.rx_flit_data),
        .msg_out   (msg),
        .count     (count)
    );

    // Next-state logic. A sof always (re)starts a message; a stray non-sof
    // in IDLE is dropped. Once the last flit lands, the link id decides
    // between delivering and discarding the message.
    always_comb begin
        next_state     = state;
        load_first     = 1'b0;
        load_next      = 1'b0;
        complete       = 1'b0;
        start_delivery = 1'b0;
        delivered      = 1'b0;
        set_framing    = 1'b0;
        set_bad        = 1'b0;
        if (flush) begin
            next_state = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (accept) begin
                        if (bus.rx_flit_sof) begin
                            load_first = 1'b1;
                            complete   = (NUM_FLITS == 1);
                            next_state = RX_ASSEMBLE;
                        end else begin
                            set_framing = 1'b1;
                        end
                    end
                end
                RX_ASSEMBLE: begin
                    if (accept) begin
                        if (bus.rx_flit_sof) begin
                            set_framing = 1'b1;
                            load_first  = 1'b1;
                            complete    = (NUM_FLITS == 1);
                        end else begin
                            load_next = 1'b1;
                            complete  = (count == COUNT_WIDTH'(NUM_FLITS - 1));
                        end
                    end
                end
                RX_DELIVER: begin
                    if (bus.fifo_input_ready[link_q]) begin
                        delivered  = 1'b1;
                        next_state = RX_IDLE;
                    end
                end
                default: next_state = RX_IDLE;
            endcase
            if (complete) begin
                if (int'(link_id) >= NUM_LINKS) begin
                    set_bad    = 1'b1;
                    next_state = RX_IDLE;
                end else begin
                    start_delivery = 1'b1;
                    next_state     = RX_DELIVER;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Delivery strobe and data are registered and held until the addressed
    // link accepts; every slice other than the target reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
            link_q  <= '0;
        end else if (flush || delivered) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (start_delivery) begin
            valid_q <= NUM_LINKS'(1) << link_id;
            data_q  <= DATA_WIDTH'(msg[FIFO_DATA_SIZE-1:0]) << (int'(link_id) * FIFO_DATA_SIZE);
            link_q  <= link_id;
        end
    end

    // Sticky error flags and saturating delivery counter; only reset clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            framing_error  <= 1'b0;
            bad_link_error <= 1'b0;
            msg_count      <= '0;
        end else begin
            if (set_framing) framing_error <= 1'b1;
            if (set_bad) bad_link_error <= 1'b1;
            if (delivered && (msg_count != 16'hFFFF)) msg_count <= msg_count + 16'd1;
        end
    end

    assign bus.fifo_input_valid = valid_q;
    assign bus.fifo_input_data  = data_q;

endmodule

// File: tb/tb_boundary_link_rx.sv
// ---------------------------------------------------------------------------
// tb_boundary_link_rx
// Directed bench for boundary_link_rx: a default instance (8 links) checked
// every cycle against a message-level model, and a 6-link instance for the
// out-of-range link id case.
// ---------------------------------------------------------------------------
module tb_boundary_link_rx;
    import boundary_link_rx_pkg::*;

    localparam int NL        = 8;
    localparam int FDS       = 10;
    localparam int MSG_W     = 13;
    localparam int N_FLITS   = (MSG_W + 7) / 8;

    logic                   clk;
    logic                   reset_n;
    logic [STAGE_WIDTH-1:0] stage;
    logic                   framing;
    logic                   bad;
    logic [15:0]            mcount;
    logic                   framing6;
    logic                   bad6;
    logic [15:0]            mcount6;

    int check_count = 0;
    int pass_count  = 0;

    boundary_link_rx_if #(.NUM_LINKS(NL), .FLIT_WIDTH(8), .FIFO_DATA_SIZE(FDS)) ifc ();
    boundary_link_rx_if #(.NUM_LINKS(6),  .FLIT_WIDTH(8), .FIFO_DATA_SIZE(FDS)) ifc6 ();

    boundary_link_rx #(.ADDRESS_WIDTH(6), .NUM_LINKS(NL), .FLIT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset_n),
        .global_stage  (stage),
        .bus           (ifc.slave),
        .framing_error (framing),
        .bad_link_error(bad),
        .msg_count     (mcount)
    );

    boundary_link_rx #(.ADDRESS_WIDTH(6), .NUM_LINKS(6), .FLIT_WIDTH(8)) dut6 (
        .clk           (clk),
        .reset         (reset_n),
        .global_stage  (stage),
        .bus           (ifc6.slave),
        .framing_error (framing6),
        .bad_link_error(bad6),
        .msg_count     (mcount6)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message-level model state: flits collected so far and the pending
    // delivery waiting for its link to accept.
    logic [7:0] m_flits[$];
    bit         m_pend      = 1'b0;
    int         m_link      = 0;
    logic [9:0] m_data      = '0;
    bit         m_framing   = 1'b0;
    bit         m_bad       = 1'b0;
    int         m_count     = 0;

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one flit from just after a rising edge and hold it until an
    // edge at which the receiver was ready.
    task automatic applyStimulus(input logic [7:0] d, input logic s);
        int budget = 50;
        bit took   = 1'b0;
        ifc.rx_flit_data  = d;
        ifc.rx_flit_sof   = s;
        ifc.rx_flit_valid = 1'b1;
        while (!took && budget > 0) begin
            @(negedge clk);
            took = ifc.rx_flit_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        ifc.rx_flit_valid = 1'b0;
        ifc.rx_flit_sof   = 1'b0;
        if (!took) checkOutput("flit_accept_timeout", 80'd0, 80'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model update on each edge, from the protocol rules at message level.
    initial begin
        logic [15:0] msg;
        int          link;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_flits.delete();
                m_pend    = 1'b0;
                m_framing = 1'b0;
                m_bad     = 1'b0;
                m_count   = 0;
            end else if (stage == STAGE_MEASUREMENT_LOADING) begin
                m_flits.delete();
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (ifc.fifo_input_ready[m_link]) begin
                    m_pend = 1'b0;
                    if (m_count < 65535) m_count++;
                end
            end else if (ifc.rx_flit_valid) begin
                if (ifc.rx_flit_sof) begin
                    if (m_flits.size() != 0) m_framing = 1'b1;
                    m_flits.delete();
                    m_flits.push_back(ifc.rx_flit_data);
                end else if (m_flits.size() == 0) begin
                    m_framing = 1'b1;
                end else begin
                    m_flits.push_back(ifc.rx_flit_data);
                end
                if (m_flits.size() == N_FLITS) begin
                    msg = {m_flits[1], m_flits[0]} & 16'h1FFF;
                    link = int'(msg >> FDS);
                    if (link >= NL) begin
                        m_bad = 1'b1;
                    end else begin
                        m_pend = 1'b1;
                        m_link = link;
                        m_data = msg[9:0];
                    end
                    m_flits.delete();
                end
            end
        end
    end

    // Per-cycle comparison of every output of the default instance.
    initial begin
        logic [79:0] exp_data;
        logic [7:0]  exp_valid;
        forever begin
            @(negedge clk);
            exp_valid = m_pend ? (8'd1 << m_link) : 8'd0;
            exp_data  = m_pend ? (80'(m_data) << (m_link * FDS)) : 80'd0;
            checkOutput("cyc_ready", 80'(ifc.rx_flit_ready),
                        80'((stage == STAGE_MEASUREMENT_LOADING) || !m_pend));
            checkOutput("cyc_valid", 80'(ifc.fifo_input_valid), 80'(exp_valid));
            checkOutput("cyc_data", ifc.fifo_input_data, exp_data);
            checkOutput("cyc_framing", 80'(framing), 80'(m_framing));
            checkOutput("cyc_bad", 80'(bad), 80'(m_bad));
            checkOutput("cyc_count", 80'(mcount), 80'(m_count));
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        reset_n                = 1'b0;
        stage                  = STAGE_IDLE;
        ifc.rx_flit_data       = '0;
        ifc.rx_flit_sof        = 1'b0;
        ifc.rx_flit_valid      = 1'b0;
        ifc.fifo_input_ready   = '1;
        ifc6.rx_flit_data      = '0;
        ifc6.rx_flit_sof       = 1'b0;
        ifc6.rx_flit_valid     = 1'b0;
        ifc6.fifo_input_ready  = '1;

        #12;
        checkOutput("rst_ready", 80'(ifc.rx_flit_ready), 80'd1);
        checkOutput("rst_valid", 80'(ifc.fifo_input_valid), 80'd0);
        checkOutput("rst_count", 80'(mcount), 80'd0);
        checkOutput("rst_bad6", 80'(bad6), 80'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Plain two-flit message to link 2: msg 0x0A55 -> data 0x255.
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("t1_valid", 80'(ifc.fifo_input_valid), 80'h04);
        checkOutput("t1_data", 80'(ifc.fifo_input_data[29:20]), 80'h255);
        idle(1);
        checkOutput("t1_valid_drop", 80'(ifc.fifo_input_valid), 80'h00);
        checkOutput("t1_count", 80'(mcount), 80'd1);

        // Same message with link 2 back-pressured for 5 cycles.
        ifc.fifo_input_ready[2] = 1'b0;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_valid_hold", 80'(ifc.fifo_input_valid), 80'h04);
            checkOutput("t2_data_hold", 80'(ifc.fifo_input_data[29:20]), 80'h255);
            checkOutput("t2_ready_low", 80'(ifc.rx_flit_ready), 80'd0);
            idle(1);
        end
        ifc.fifo_input_ready[2] = 1'b1;
        checkOutput("t2_valid_last", 80'(ifc.fifo_input_valid), 80'h04);
        idle(1);
        checkOutput("t2_valid_drop", 80'(ifc.fifo_input_valid), 80'h00);
        checkOutput("t2_count", 80'(mcount), 80'd2);

        // Stray non-sof flit in IDLE, then a good message to link 0.
        applyStimulus(8'h11, 1'b0);
        checkOutput("t3_framing", 80'(framing), 80'd1);
        checkOutput("t3_no_strobe", 80'(ifc.fifo_input_valid), 80'h00);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t3_valid", 80'(ifc.fifo_input_valid), 80'h01);
        checkOutput("t3_data", 80'(ifc.fifo_input_data[9:0]), 80'h001);
        idle(1);
        checkOutput("t3_count", 80'(mcount), 80'd3);

        // Reset asserted while a message is half assembled.
        applyStimulus(8'h33, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_count", 80'(mcount), 80'd0);
        checkOutput("t6_rst_framing", 80'(framing), 80'd0);
        checkOutput("t6_rst_ready", 80'(ifc.rx_flit_ready), 80'd1);
        checkOutput("t6_rst_valid", 80'(ifc.fifo_input_valid), 80'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);

        // sof interrupts a partial message; only link 7 gets data 0x007.
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h1C, 1'b0);
        checkOutput("t4_framing", 80'(framing), 80'd1);
        checkOutput("t4_valid", 80'(ifc.fifo_input_valid), 80'h80);
        checkOutput("t4_data", 80'(ifc.fifo_input_data[79:70]), 80'h007);
        idle(1);
        checkOutput("t4_count", 80'(mcount), 80'd1);

        // Measurement loading arrives together with ready while delivering.
        ifc.fifo_input_ready = '0;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("t6_stage_valid", 80'(ifc.fifo_input_valid), 80'h04);
        stage                = STAGE_MEASUREMENT_LOADING;
        ifc.fifo_input_ready = '1;
        #1;
        checkOutput("t6_stage_ready", 80'(ifc.rx_flit_ready), 80'd1);
        idle(1);
        checkOutput("t6_stage_cleared", 80'(ifc.fifo_input_valid), 80'h00);
        checkOutput("t6_stage_count", 80'(mcount), 80'd1);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("t6_flush_framing", 80'(framing), 80'd1);
        checkOutput("t6_flush_valid", 80'(ifc.fifo_input_valid), 80'h00);
        stage = STAGE_DECODING;
        idle(1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t6_recover_valid", 80'(ifc.fifo_input_valid), 80'h01);
        idle(1);
        checkOutput("t6_recover_count", 80'(mcount), 80'd2);

        // Six-link instance: link id 7 is out of range.
        ifc6.rx_flit_data  = 8'h00;
        ifc6.rx_flit_sof   = 1'b1;
        ifc6.rx_flit_valid = 1'b1;
        idle(1);
        ifc6.rx_flit_data  = 8'h1C;
        ifc6.rx_flit_sof   = 1'b0;
        idle(1);
        ifc6.rx_flit_valid = 1'b0;
        checkOutput("t5_bad", 80'(bad6), 80'd1);
        checkOutput("t5_no_strobe", 80'(ifc6.fifo_input_valid), 80'h00);
        checkOutput("t5_ready", 80'(ifc6.rx_flit_ready), 80'd1);
        idle(1);
        checkOutput("t5_no_strobe_later", 80'(ifc6.fifo_input_valid), 80'h00);

        // Six-link instance still delivers to its top link: msg 0x142A.
        ifc6.rx_flit_data  = 8'h2A;
        ifc6.rx_flit_sof   = 1'b1;
        ifc6.rx_flit_valid = 1'b1;
        idle(1);
        ifc6.rx_flit_data  = 8'h14;
        ifc6.rx_flit_sof   = 1'b0;
        idle(1);
        ifc6.rx_flit_valid = 1'b0;
        checkOutput("t5_link5_valid", 80'(ifc6.fifo_input_valid), 80'h20);
        checkOutput("t5_link5_data", 80'(ifc6.fifo_input_data[59:50]), 80'h02A);
        idle(1);
        checkOutput("t5_link5_count", 80'(mcount6), 80'd1);
        checkOutput("t5_framing6", 80'(framing6), 80'd0);

        idle(2);
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
